// File: rtl/alu_fpga_pkg.sv
// Shared types and helpers for the FPGA ALU board controller.
package alu_fpga_pkg;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        CALC   = 3'd3,
        SHOW   = 3'd4
    } fsm_state_t;

    localparam logic [6:0] BLANK_7SEG = 7'b1111111;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// CPU-wide shared types; the ALU op encoding used by the board controller.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLT = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7
    } aluop_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser plus a counter that accepts a
// level change only after DEBOUNCE_CYCLES consecutive stable samples. Emits a
// single-cycle pulse when a press (low level) is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             held_q,  held_d;   // 1 = press accepted, waiting for release
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             press_q, press_d;

    // Count consecutive samples that disagree with the accepted state; flip it at the limit.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        held_d  = held_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // Active-low key: level differs from accepted state when sync2 equals held.
        if (sync2_q == held_q) begin
            if (cnt_q == CNT_MAX) begin
                held_d  = ~held_q;
                press_d = ~held_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; synchroniser idles high (key released).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            held_q  <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_fpga_ctrl.sv
// Board-level ALU exerciser: debounced keys drive an operand/op entry FSM,
// the ALU result is captured, and a paged hex display shows the live switch
// value during entry or the captured result afterwards.
module alu_fpga_ctrl
    import alu_fpga_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [3:0]              key_n,
    input  logic [SW_W-1:0]         sw_data,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic [2:0]              alu_flags,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [3:0]              alu_op,
    output logic [DATA_W-1:0]       result,
    output logic [2:0]              flags,
    output logic [3:0]              state_led,
    output logic                    ext_led,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int PAGES  = DATA_W / (4 * NUM_DIGITS);
    localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    logic [3:0] press;
    logic       enter_p, clear_p, page_p, ext_p;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .CLK   (CLK),
            .RST   (RST),
            .key_n (key_n[k]),
            .press (press[k])
        );
    end

    assign enter_p = press[0];
    assign clear_p = press[1];
    assign page_p  = press[2];
    assign ext_p   = press[3];

    fsm_state_t              state_q, state_d;
    logic [DATA_W-1:0]       alu_a_q, alu_a_d;
    logic [DATA_W-1:0]       alu_b_q, alu_b_d;
    aluop_t                  alu_op_q, alu_op_d;
    logic [DATA_W-1:0]       result_q, result_d;
    logic [2:0]              flags_q, flags_d;
    logic [PAGE_W-1:0]       page_q, page_d;
    logic                    ext_mode_q, ext_mode_d;
    logic [3:0]              state_led_q, state_led_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [DATA_W-1:0]       ext_val;
    logic [DATA_W-1:0]       disp;

    // Switch value widened to the datapath, sign or zero filled by ext_mode.
    always_comb begin
        ext_val = {{(DATA_W-SW_W){ext_mode_q & sw_data[SW_W-1]}}, sw_data};
    end

    // Entry FSM next state, operand capture and page counter; clear beats enter beats page.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        result_d   = result_q;
        flags_d    = flags_q;
        page_d     = page_q;
        ext_mode_d = ext_mode_q ^ ext_p;

        if (clear_p) begin
            state_d  = GET_A;
            alu_a_d  = '0;
            alu_b_d  = '0;
            alu_op_d = ALU_ADD;
            result_d = '0;
            flags_d  = '0;
        end else begin
            case (state_q)
                GET_A:  if (enter_p) begin state_d = GET_B;  alu_a_d = ext_val; end
                GET_B:  if (enter_p) begin state_d = GET_OP; alu_b_d = ext_val; end
                GET_OP: if (enter_p) begin state_d = CALC;   alu_op_d = aluop_t'(sw_data[3:0]); end
                CALC: begin
                    // ALU inputs were frozen on the previous edge; sample its output now.
                    state_d  = SHOW;
                    result_d = alu_out;
                    flags_d  = alu_flags;
                end
                SHOW:   if (enter_p) state_d = GET_A;
                default: state_d = GET_A;
            endcase
        end

        if (clear_p || (state_d != state_q)) begin
            page_d = '0;
        end else if (page_p) begin
            page_d = (page_q == PAGE_LAST) ? '0 : page_q + PAGE_W'(1);
        end

        case (state_d)
            GET_A:   state_led_d = 4'b0001;
            GET_B:   state_led_d = 4'b0010;
            GET_OP:  state_led_d = 4'b0100;
            SHOW:    state_led_d = 4'b1000;
            default: state_led_d = 4'b0000;
        endcase
    end

    // Paged digit decode of the current display value; registered below.
    always_comb begin
        disp  = (state_q == SHOW) ? result_q : ext_val;
        hex_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[i*7 +: 7] = hex7seg(disp[(int'(page_q) * NUM_DIGITS + i) * 4 +: 4]);
        end
    end

    // All controller state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= GET_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_ADD;
            result_q    <= '0;
            flags_q     <= '0;
            page_q      <= '0;
            ext_mode_q  <= 1'b1;
            state_led_q <= 4'b0001;
            hex_q       <= {NUM_DIGITS{BLANK_7SEG}};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            page_q      <= page_d;
            ext_mode_q  <= ext_mode_d;
            state_led_q <= state_led_d;
            hex_q       <= hex_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign state_led = state_led_q;
    assign ext_led   = ext_mode_q;
    assign hex       = hex_q;

endmodule

// File: tb/tb_alu_fpga_ctrl.sv
// Self-checking bench for alu_fpga_ctrl with a small ALU model and a
// result scoreboard filled at op entry and drained on entry to SHOW.
module tb_alu_fpga_ctrl;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        RST;
    logic [3:0]  key_n;
    logic [15:0] sw_data;
    logic [31:0] alu_out;
    logic [2:0]  alu_flags;
    logic [31:0] alu_a, alu_b, result;
    logic [3:0]  alu_op;
    logic [2:0]  flags;
    logic [3:0]  state_led;
    logic        ext_led;
    logic [27:0] hex;

    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [2:0]  ovr_flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } sb_t;
    sb_t sb_q[$];

    alu_fpga_ctrl #(
        .DATA_W(32), .SW_W(16), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST(RST), .key_n(key_n), .sw_data(sw_data),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .result(result), .flags(flags), .state_led(state_led),
        .ext_led(ext_led), .hex(hex)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU driven by the DUT operands; can be overridden for display tests.
    always_comb begin
        logic [31:0] r;
        logic        ovf;
        ovf = 1'b0;
        case (alu_op)
            ALU_ADD: begin r = alu_a + alu_b; ovf = (alu_a[31] == alu_b[31]) && (r[31] != alu_a[31]); end
            ALU_SUB: begin r = alu_a - alu_b; ovf = (alu_a[31] != alu_b[31]) && (r[31] != alu_a[31]); end
            ALU_AND: r = alu_a & alu_b;
            ALU_OR:  r = alu_a | alu_b;
            ALU_XOR: r = alu_a ^ alu_b;
            default: r = 32'h0;
        endcase
        if (ovr_en) begin
            alu_out   = ovr_val;
            alu_flags = ovr_flags;
        end else begin
            alu_out   = r;
            alu_flags = {ovf, r[31], (r == 32'h0)};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Active-high glyph table inverted to active-low.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] on;
        case (n)
            4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
            4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
            4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
            4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    function automatic logic [27:0] exp_hex(input logic [31:0] v, input int pg);
        logic [27:0] h;
        logic [31:0] s;
        s = v >> (pg * 16);
        for (int d = 0; d < 4; d++) h[d*7 +: 7] = glyph(s[d*4 +: 4]);
        return h;
    endfunction

    task automatic press_key(input int idx, input int hold);
        @(negedge CLK);
        key_n[idx] = 1'b0;
        repeat (hold) @(negedge CLK);
        key_n[idx] = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    task automatic enter_val(input logic [15:0] v);
        sw_data = v;
        press_key(0, 10);
    endtask

    // Enter in GET_OP; result must be present one cycle after CALC is seen.
    task automatic enter_op(input logic [15:0] op);
        int n;
        sw_data = op;
        @(negedge CLK);
        key_n[0] = 1'b0;
        n = 0;
        while (state_led != 4'b0000 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("calc_reached", {31'b0, n < 40}, 32'd1);
        @(negedge CLK);
        check("show_latency", state_led, 4'b1000);
        repeat (9) @(negedge CLK);
        key_n[0] = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    // Scoreboard drain on every entry into SHOW.
    logic [3:0] prev_led = 4'b0001;
    always @(negedge CLK) begin
        if (state_led == 4'b1000 && prev_led != 4'b1000) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_result", result, e.res);
                check("sb_flags", {29'b0, flags}, {29'b0, e.flg});
            end
        end
        prev_led = state_led;
    end

    initial begin
        RST = 1'b1; key_n = 4'hF; sw_data = 16'h0;
        ovr_en = 1'b0; ovr_val = 32'h0; ovr_flags = 3'b0;
        repeat (3) @(negedge CLK);
        check("rst_state_led", state_led, 4'b0001);
        check("rst_hex", hex, 28'hFFFFFFF);
        check("rst_ext_led", ext_led, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_result", result, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_hex", hex, exp_hex(32'h0, 0));

        // Reset while in GET_OP takes effect without a clock edge.
        enter_val(16'h1234);
        check("pre_alu_a", alu_a, 32'h00001234);
        enter_val(16'h0005);
        check("pre_alu_b", alu_b, 32'h00000005);
        check("pre_state", state_led, 4'b0100);
        #2 RST = 1'b1;
        #1;
        check("arst_state_led", state_led, 4'b0001);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_hex", hex, 28'hFFFFFFF);
        check("arst_ext_led", ext_led, 1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Sign-extended entry flow with ADD.
        enter_val(16'h8001);
        check("flow_alu_a", alu_a, 32'hFFFF8001);
        check("flow_live_hex", hex, exp_hex(32'hFFFF8001, 0));
        enter_val(16'h0001);
        check("flow_alu_b", alu_b, 32'h00000001);
        sb_q.push_back('{res: 32'hFFFF8002, flg: 3'b010});
        enter_op(16'(ALU_ADD));
        check("flow_show_led", state_led, 4'b1000);
        check("flow_show_hex", hex, exp_hex(32'hFFFF8002, 0));

        // Debounce: short press, long hold, glitch while held.
        @(negedge CLK);
        key_n[0] = 1'b0;
        repeat (3) @(negedge CLK);
        key_n[0] = 1'b1;
        repeat (15) @(negedge CLK);
        check("deb_short", state_led, 4'b1000);
        key_n[0] = 1'b0;
        repeat (100) @(negedge CLK);
        check("deb_hold_one", state_led, 4'b0001);
        key_n[0] = 1'b1;
        @(negedge CLK);
        key_n[0] = 1'b0;
        repeat (20) @(negedge CLK);
        check("deb_glitch", state_led, 4'b0001);
        key_n[0] = 1'b1;
        repeat (15) @(negedge CLK);

        // Paging over a known result.
        ovr_en = 1'b1; ovr_val = 32'h12345678; ovr_flags = 3'b000;
        enter_val(16'h0001);
        enter_val(16'h0002);
        sb_q.push_back('{res: 32'h12345678, flg: 3'b000});
        enter_op(16'(ALU_ADD));
        check("page0_hex", hex, exp_hex(32'h12345678, 0));
        press_key(2, 10);
        check("page1_hex", hex, exp_hex(32'h12345678, 1));
        press_key(2, 10);
        check("page_wrap_hex", hex, exp_hex(32'h12345678, 0));
        check("page_stay_show", state_led, 4'b1000);
        ovr_en = 1'b0;
        enter_val(16'h0000);
        check("show_to_a", state_led, 4'b0001);

        // Clear and enter on the same cycle in GET_B.
        enter_val(16'h0007);
        check("clr_pre_a", alu_a, 32'h7);
        @(negedge CLK);
        key_n[1:0] = 2'b00;
        repeat (10) @(negedge CLK);
        key_n = 4'hF;
        repeat (12) @(negedge CLK);
        check("clr_state", state_led, 4'b0001);
        check("clr_alu_a", alu_a, 0);
        check("clr_alu_b", alu_b, 0);
        check("clr_result", result, 0);
        check("clr_ext_kept", ext_led, 1);

        // Zero extension and SUB to zero.
        press_key(3, 10);
        check("ext_led_off", ext_led, 0);
        sw_data = 16'h8001;
        repeat (2) @(negedge CLK);
        check("ext_live_hex", hex, exp_hex(32'h00008001, 0));
        enter_val(16'h8001);
        check("ext_alu_a", alu_a, 32'h00008001);
        enter_val(16'h8001);
        check("ext_alu_b", alu_b, 32'h00008001);
        sb_q.push_back('{res: 32'h0, flg: 3'b001});
        enter_op(16'(ALU_SUB));
        check("sub_alu_op", alu_op, 4'(ALU_SUB));
        check("sub_hex", hex, exp_hex(32'h0, 0));

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
